// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: LSU > MDU > ALU fixed priority with a
// per-requester aging override, and a one-cycle registered write port.
module regfile_wb_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            wb_stall_i,
  input  logic            lsu_valid_i,
  input  logic [4:0]      lsu_rd_i,
  input  logic [XLEN-1:0] lsu_data_i,
  output logic            lsu_ready_o,
  input  logic            mdu_valid_i,
  input  logic [4:0]      mdu_rd_i,
  input  logic [XLEN-1:0] mdu_data_i,
  output logic            mdu_ready_o,
  input  logic            alu_valid_i,
  input  logic [4:0]      alu_rd_i,
  input  logic [XLEN-1:0] alu_data_i,
  output logic            alu_ready_o,
  output logic            reg_wr_en_o,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] wr_data_o,
  output logic [2:0]      grant_o
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [2:0]      w_valid;
  logic [2:0]      w_starved;
  logic [2:0]      w_cand;
  logic [2:0]      w_grant;
  logic [4:0]      w_sel_rd;
  logic [XLEN-1:0] w_sel_data;
  logic [3:0]      r_cnt [3];
  logic            r_wr_en;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_data;
  logic [2:0]      r_grant;

  assign w_valid = {alu_valid_i, mdu_valid_i, lsu_valid_i};

  // Starved flags and one-hot grant; starved requesters form the candidate set when any exist.
  always_comb begin
    w_starved = 3'b000;
    w_cand    = 3'b000;
    w_grant   = 3'b000;
    for (int i = 0; i < 3; i++) begin
      w_starved[i] = (r_cnt[i] == LIMIT);
    end
    if (!rst_ni || wb_stall_i) begin
      w_cand = 3'b000;
    end else if ((w_valid & w_starved) != 3'b000) begin
      w_cand = w_valid & w_starved;
    end else begin
      w_cand = w_valid;
    end
    if (w_cand[0]) begin
      w_grant = 3'b001;
    end else if (w_cand[1]) begin
      w_grant = 3'b010;
    end else if (w_cand[2]) begin
      w_grant = 3'b100;
    end else begin
      w_grant = 3'b000;
    end
  end

  assign lsu_ready_o = w_grant[0];
  assign mdu_ready_o = w_grant[1];
  assign alu_ready_o = w_grant[2];

  // Winner's destination and data.
  always_comb begin
    w_sel_rd   = 5'd0;
    w_sel_data = '0;
    case (w_grant)
      3'b001: begin
        w_sel_rd   = lsu_rd_i;
        w_sel_data = lsu_data_i;
      end
      3'b010: begin
        w_sel_rd   = mdu_rd_i;
        w_sel_data = mdu_data_i;
      end
      3'b100: begin
        w_sel_rd   = alu_rd_i;
        w_sel_data = alu_data_i;
      end
      default: begin
        w_sel_rd   = 5'd0;
        w_sel_data = '0;
      end
    endcase
  end

  // Wait counters: clear on grant or idle, freeze under stall, saturate at the limit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 3; i++) begin
        r_cnt[i] <= 4'd0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (w_grant[i] || !w_valid[i]) begin
          r_cnt[i] <= 4'd0;
        end else if (wb_stall_i) begin
          r_cnt[i] <= r_cnt[i];
        end else if (r_cnt[i] != LIMIT) begin
          r_cnt[i] <= r_cnt[i] + 4'd1;
        end else begin
          r_cnt[i] <= r_cnt[i];
        end
      end
    end
  end

  // Output register; x0 writes are granted but never enable the register file.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_en <= 1'b0;
      r_rd    <= 5'd0;
      r_data  <= '0;
      r_grant <= 3'b000;
    end else if (w_grant != 3'b000) begin
      r_wr_en <= (w_sel_rd != 5'd0);
      r_rd    <= w_sel_rd;
      r_data  <= w_sel_data;
      r_grant <= w_grant;
    end else begin
      r_wr_en <= 1'b0;
      r_rd    <= r_rd;
      r_data  <= r_data;
      r_grant <= 3'b000;
    end
  end

  assign reg_wr_en_o = r_wr_en;
  assign rd_addr_o   = r_rd;
  assign wr_data_o   = r_data;
  assign grant_o     = r_grant;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: the driver checks ready and queues the
// expected write; a negedge monitor compares the registered port every cycle.
module tb_regfile_wb_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        wb_stall_i;
  logic        lsu_valid_i, mdu_valid_i, alu_valid_i;
  logic [4:0]  lsu_rd_i, mdu_rd_i, alu_rd_i;
  logic [31:0] lsu_data_i, mdu_data_i, alu_data_i;
  logic        lsu_ready_o, mdu_ready_o, alu_ready_o;
  logic        reg_wr_en_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] wr_data_o;
  logic [2:0]  grant_o;

  typedef struct {
    logic        en;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [2:0]  grant;
    int          due;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [4:0]  exp_rd = 5'd0;
  logic [31:0] exp_data = 32'd0;

  regfile_wb_arbiter #(.XLEN(32), .STARVE_LIMIT(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .wb_stall_i(wb_stall_i),
    .lsu_valid_i(lsu_valid_i), .lsu_rd_i(lsu_rd_i), .lsu_data_i(lsu_data_i), .lsu_ready_o(lsu_ready_o),
    .mdu_valid_i(mdu_valid_i), .mdu_rd_i(mdu_rd_i), .mdu_data_i(mdu_data_i), .mdu_ready_o(mdu_ready_o),
    .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i), .alu_ready_o(alu_ready_o),
    .reg_wr_en_o(reg_wr_en_o), .rd_addr_o(rd_addr_o), .wr_data_o(wr_data_o), .grant_o(grant_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    forever begin
      @(posedge clk_i);
      cyc++;
    end
  end

  task automatic cmp_port(input logic en, input logic [4:0] rd, input logic [31:0] data,
                          input logic [2:0] gr, input string nm);
    checks++;
    if ({reg_wr_en_o, rd_addr_o, wr_data_o, grant_o} !== {en, rd, data, gr}) begin
      errors++;
      $display("FAIL %s: got en=%b rd=%0d data=%h grant=%b, expected en=%b rd=%0d data=%h grant=%b",
               nm, reg_wr_en_o, rd_addr_o, wr_data_o, grant_o, en, rd, data, gr);
    end
  endtask

  task automatic cmp_ready(input logic [2:0] exp, input string nm);
    checks++;
    if ({alu_ready_o, mdu_ready_o, lsu_ready_o} !== exp) begin
      errors++;
      $display("FAIL %s: ready(alu,mdu,lsu)=%b expected %b", nm,
               {alu_ready_o, mdu_ready_o, lsu_ready_o}, exp);
    end
  endtask

  // Monitor: pops the expected write in its due cycle, otherwise expects an idle, holding port.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        q.delete();
        exp_rd   = 5'd0;
        exp_data = 32'd0;
        cmp_port(1'b0, 5'd0, 32'd0, 3'b000, "reset_port");
      end else if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        cmp_port(e.en, e.rd, e.data, e.grant, "write");
        exp_rd   = e.rd;
        exp_data = e.data;
      end else begin
        cmp_port(1'b0, exp_rd, exp_data, 3'b000, "idle_hold");
      end
    end
  end

  // Requester rule: a pending valid must not drop before its handshake.
  initial begin
    logic [2:0] pend;
    pend = 3'b000;
    forever begin
      @(posedge clk_i);
      if (!rst_ni) begin
        pend = 3'b000;
      end else begin
        if ((pend & ~{alu_valid_i, mdu_valid_i, lsu_valid_i}) != 3'b000) begin
          errors++;
          $display("FAIL req_rule: valid dropped before handshake, pending=%b", pend);
        end
        pend = {alu_valid_i, mdu_valid_i, lsu_valid_i} & ~{alu_ready_o, mdu_ready_o, lsu_ready_o};
      end
    end
  end

  task automatic req_lsu(input logic [4:0] rd, input logic [31:0] d);
    lsu_valid_i = 1'b1; lsu_rd_i = rd; lsu_data_i = d;
  endtask
  task automatic req_mdu(input logic [4:0] rd, input logic [31:0] d);
    mdu_valid_i = 1'b1; mdu_rd_i = rd; mdu_data_i = d;
  endtask
  task automatic req_alu(input logic [4:0] rd, input logic [31:0] d);
    alu_valid_i = 1'b1; alu_rd_i = rd; alu_data_i = d;
  endtask

  // One cycle: check ready at negedge, queue the expected write, retire accepted requests.
  task automatic step(input logic [2:0] exp, input string nm);
    exp_t e;
    @(negedge clk_i);
    cmp_ready(exp, nm);
    e.due = cyc + 1;
    if (exp[0]) begin
      e.en = (lsu_rd_i != 5'd0); e.rd = lsu_rd_i; e.data = lsu_data_i; e.grant = 3'b001;
      q.push_back(e);
    end
    if (exp[1]) begin
      e.en = (mdu_rd_i != 5'd0); e.rd = mdu_rd_i; e.data = mdu_data_i; e.grant = 3'b010;
      q.push_back(e);
    end
    if (exp[2]) begin
      e.en = (alu_rd_i != 5'd0); e.rd = alu_rd_i; e.data = alu_data_i; e.grant = 3'b100;
      q.push_back(e);
    end
    @(posedge clk_i);
    #1;
    if (exp[0]) lsu_valid_i = 1'b0;
    if (exp[1]) mdu_valid_i = 1'b0;
    if (exp[2]) alu_valid_i = 1'b0;
  endtask

  initial begin
    int k;
    rst_ni = 1'b0; wb_stall_i = 1'b0;
    lsu_valid_i = 1'b1; mdu_valid_i = 1'b0; alu_valid_i = 1'b0;
    lsu_rd_i = 5'd1; mdu_rd_i = 5'd0; alu_rd_i = 5'd0;
    lsu_data_i = 32'd0; mdu_data_i = 32'd0; alu_data_i = 32'd0;
    #3;
    cmp_ready(3'b000, "ready_in_reset");
    cmp_port(1'b0, 5'd0, 32'd0, 3'b000, "port_in_reset");
    @(posedge clk_i); @(posedge clk_i); #1;
    lsu_valid_i = 1'b0;
    rst_ni = 1'b1;
    step(3'b000, "idle_after_reset");

    // All three at once: LSU, then MDU, then ALU.
    req_lsu(5'd5, 32'hDEADBEEF);
    req_mdu(5'd6, 32'h66666666);
    req_alu(5'd7, 32'h77777777);
    step(3'b001, "prio_lsu");
    step(3'b010, "prio_mdu");
    step(3'b100, "prio_alu");
    step(3'b000, "prio_idle");

    // Continuous LSU traffic: ALU wins after four losses, twice (counter restarts from 0).
    k = 0;
    req_lsu(5'd8, 32'h00000100);
    for (int rep = 0; rep < 2; rep++) begin
      req_alu(5'(3 + rep), 32'hA1A1A1A0 + 32'(rep));
      for (int i = 0; i < 4; i++) begin
        step(3'b001, "starve_lsu_wins");
        k++;
        req_lsu(5'(8 + k), 32'h00000100 + 32'(k));
      end
      step(3'b100, "starve_alu_promoted");
    end
    step(3'b001, "starve_drain");
    step(3'b000, "starve_idle");

    // x0 write is granted without a register-file write.
    req_alu(5'd0, 32'h12345678);
    step(3'b100, "x0_alu");
    step(3'b000, "x0_idle");

    // Stall blocks the MDU, which is accepted as soon as stall drops.
    req_mdu(5'd9, 32'h99999999);
    wb_stall_i = 1'b1;
    for (int i = 0; i < 3; i++) step(3'b000, "stall_no_ready");
    wb_stall_i = 1'b0;
    step(3'b010, "stall_release_mdu");

    // MDU waits 3 cycles, stall holds its counter at 3, so it needs exactly one more loss.
    req_lsu(5'd16, 32'h16161616);
    req_mdu(5'd11, 32'h11111111);
    for (int i = 0; i < 3; i++) begin
      step(3'b001, "hold_lsu_wins");
      req_lsu(5'(17 + i), 32'h17171717 + 32'(i));
    end
    wb_stall_i = 1'b1;
    for (int i = 0; i < 3; i++) step(3'b000, "hold_stalled");
    wb_stall_i = 1'b0;
    step(3'b001, "hold_lsu_last_win");
    req_lsu(5'd22, 32'h22222222);
    step(3'b010, "hold_mdu_starved");
    step(3'b001, "hold_drain");
    step(3'b000, "hold_idle");

    // Back-to-back ALU writes rd=1..4.
    for (int i = 1; i <= 4; i++) begin
      req_alu(5'(i), 32'h11111111 * 32'(i));
      step(3'b100, "b2b_alu");
    end
    step(3'b000, "b2b_idle");

    // Asynchronous reset while a write is on the port.
    req_alu(5'd20, 32'hCAFEF00D);
    step(3'b100, "midreset_alu");
    #1;
    rst_ni = 1'b0;
    #1;
    cmp_port(1'b0, 5'd0, 32'd0, 3'b000, "async_reset_clear");
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    step(3'b000, "post_reset_idle");
    step(3'b000, "post_reset_idle2");

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_empty: %0d pending expected writes, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port between three writeback sources: LSU load return, multi-cycle MUL/DIV unit (MDU) and ALU. Each source uses a valid/ready handshake. Fixed priority applies, with an aging override so no source starves. The winning write is registered and driven to the register file's write-enable, destination-address and write-data inputs one cycle after the handshake.

Parameters:
XLEN, 32, data width of the write port.
STARVE_LIMIT, 4, consecutive lost cycles after which a requester is promoted to top priority; legal range 1..15.

Ports:
clk_i  input  1  core clock, rising edge.
rst_ni  input  1  reset; asynchronous, active-low.
wb_stall_i  input  1  freezes arbitration; no grants while high.
lsu_valid_i  input  1  LSU write request.
lsu_rd_i  input  5  LSU destination register.
lsu_data_i  input  XLEN  LSU write data.
lsu_ready_o  output  1  LSU request accepted this cycle.
mdu_valid_i  input  1  MDU write request.
mdu_rd_i  input  5  MDU destination register.
mdu_data_i  input  XLEN  MDU write data.
mdu_ready_o  output  1  MDU request accepted this cycle.
alu_valid_i  input  1  ALU write request.
alu_rd_i  input  5  ALU destination register.
alu_data_i  input  XLEN  ALU write data.
alu_ready_o  output  1  ALU request accepted this cycle.
reg_wr_en_o  output  1  register-file write enable.
rd_addr_o  output  5  register-file destination address.
wr_data_o  output  XLEN  register-file write data.
grant_o  output  3  one-hot winner of the previous cycle: bit0 LSU, bit1 MDU, bit2 ALU.

Behaviour:
- Reset (rst_ni low, asynchronous): reg_wr_en_o=0, rd_addr_o=0, wr_data_o=0, grant_o=0, all starvation counters=0. Combinational ready outputs are 0 while reset is asserted. A write registered before reset is discarded and never appears on the port.
- Handshake: a transfer occurs when valid && ready in the same cycle. At most one ready_o is high per cycle, and only for a requester whose valid is high. ready_o is combinational from the valids, the counters and wb_stall_i.
- Requester rule: once valid is raised it stays high, with rd and data stable, until the handshake. The bench asserts this.
- Priority: normally LSU > MDU > ALU.
- Aging: each requester has a 4-bit wait counter.
  - +1 per cycle in which it is valid, not granted and wb_stall_i is low.
  - Holds while wb_stall_i is high.
  - Clears on grant or whenever its valid is low.
  - Saturates at STARVE_LIMIT.
- Starved state: a counter equal to STARVE_LIMIT marks its requester starved. Starved requesters beat all non-starved ones; ties among starved requesters resolve LSU > MDU > ALU.
- Latency: the handshake in cycle N drives reg_wr_en_o, rd_addr_o, wr_data_o and grant_o in cycle N+1. These are registered and stay valid for exactly one cycle.
- If no handshake in cycle N: reg_wr_en_o=0 in N+1, rd_addr_o and wr_data_o hold their previous values, grant_o=0.
- x0 writes: a request with rd=0 is still arbitrated and handshaken, and grant_o is set. reg_wr_en_o stays 0.
- wb_stall_i high: all ready_o=0. The registered output still retires the write accepted in the previous cycle.
- Throughput: one write per cycle. No buffering beyond the output register.

Test Plan:
1. Reset release, no requests -> reg_wr_en_o=0, grant_o=0, all ready_o=0; assert rst_ni low mid-write -> port clears in the same cycle, with no clock edge needed.
2. LSU (rd=5, 0xDEADBEEF), MDU (rd=6) and ALU (rd=7) all valid in cycle N -> lsu_ready_o=1 in N; cycle N+1: reg_wr_en_o=1, rd_addr_o=5, wr_data_o=0xDEADBEEF, grant_o=001; then MDU in N+1 and ALU in N+2.
3. LSU valid continuously with new writes, ALU valid (rd=3), STARVE_LIMIT=4 -> ALU loses 4 cycles, then alu_ready_o=1 in the 5th cycle; rd_addr_o=3 one cycle later; ALU counter returns to 0.
4. ALU request with rd=0, data 0x12345678 -> alu_ready_o=1, grant_o=100 next cycle, reg_wr_en_o=0.
5. wb_stall_i high for 3 cycles with MDU valid -> no ready_o in those cycles and the MDU counter holds; stall drops -> mdu_ready_o=1 in the same cycle.
6. Back-to-back ALU writes rd=1..4 with no contention -> reg_wr_en_o=1 for 4 consecutive cycles, rd_addr_o = 1, 2, 3, 4.
